// File: rtl/seq_fixed_multiplier.sv
// rtl/seq_fixed_multiplier.sv - sequential unsigned fixed-point shift-add multiplier
module seq_fixed_multiplier #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclr,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  output logic [WIDTH-1:0] qout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   hi_sum;
  logic [AW-1:0]    acc_add;
  logic             last_iter;

  assign hi_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
  assign acc_add   = b_q[0] ? {hi_sum, acc_q[WIDTH-1:0]} : acc_q;
  assign last_iter = (cnt_q == LAST_CNT);

  assign busy  = (state_q == S_CALC);
  assign valid = (state_q == S_DONE);
  assign qout  = qout_q;
  assign ovf   = ovf_q;

  // Next-state logic: controller transitions and one shift-add step per CALC cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    qout_d  = qout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = acc_add >> 1;
        b_d   = {acc_add[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          // The shifted accumulator now holds the full 2*WIDTH-bit product.
          qout_d  = acc_d[WIDTH+FRAC-1:FRAC];
          ovf_d   = |acc_d[2*WIDTH-1:WIDTH+FRAC];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; sclr clears everything like reset but on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (sclr) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      qout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      qout_q  <= qout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_fixed_multiplier.sv
// tb/tb_seq_fixed_multiplier.sv - self-checking bench for seq_fixed_multiplier
module tb_seq_fixed_multiplier;

  localparam int W = 10;
  localparam int F = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclr = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         start = 1'b0;
  logic         busy, valid, ovf;
  logic [W-1:0] qout;

  int checks = 0;
  int errors = 0;

  seq_fixed_multiplier #(.WIDTH(W), .FRAC(F)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sclr (sclr),
    .in_a (in_a),
    .in_b (in_b),
    .start(start),
    .busy (busy),
    .valid(valid),
    .ovf  (ovf),
    .qout (qout)
  );

  always #5 clk = ~clk;

  // Reference: full product, drop FRAC LSBs, keep low W bits, flag anything above.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic o);
    longint p;
    longint s;
    p = longint'(a) * longint'(b);
    s = p >>> F;
    q = s[W-1:0];
    o = (s >>> W) != 0;
  endfunction

  // One full operation from IDLE; returns latency, busy cycles and the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt,
                       output logic [W-1:0] q, output logic o);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      if (valid) break;
      @(posedge clk); #1;
      lat++;
    end
    q = qout;
    o = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, bcnt, vcount;
    logic [W-1:0] q, eq;
    logic o, eo;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (qout !== '0)    begin errors++; $display("FAIL reset_qout got=%0d exp=0", qout); end
    @(negedge clk); rst_n = 1'b1;
    do_op(10'd1023, 10'd1023, lat, bcnt, q, o);
    @(negedge clk);
    in_a = 10'd500; in_b = 10'd600; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", valid); end
    checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL async_rst_ovf got=%b exp=0", ovf); end
    checks++; if (qout !== '0)    begin errors++; $display("FAIL async_rst_qout got=%0d exp=0", qout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL rst_no_valid got=%0d exp=0", vcount); end
    do_op(10'd100, 10'd200, lat, bcnt, q, o);
    model(10'd100, 10'd200, eq, eo);
    checks++; if (q !== eq || o !== eo) begin errors++; $display("FAIL rst_restart got=%0d/%b exp=%0d/%b", q, o, eq, eo); end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    logic [W-1:0] q;
    logic o;
    do_op(10'd32, 10'd48, lat, bcnt, q, o);
    checks++; if (lat !== 10)  begin errors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    checks++; if (bcnt !== 10) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=10", bcnt); end
    checks++; if (q !== 10'd48) begin errors++; $display("FAIL basic_qout got=%0d exp=48", q); end
    checks++; if (o !== 1'b0)   begin errors++; $display("FAIL basic_ovf got=%b exp=0", o); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%b exp=0", valid); end
    do_op(10'd0, 10'd777, lat, bcnt, q, o);
    checks++; if (q !== 10'd0 || o !== 1'b0) begin errors++; $display("FAIL zero_operand got=%0d/%b exp=0/0", q, o); end
  endtask

  task automatic test_limits();
    logic [W-1:0] ta [4] = '{10'd1, 10'd1023, 10'd1023, 10'd1023};
    logic [W-1:0] tb [4] = '{10'd1, 10'd32, 10'd33, 10'd1023};
    logic [W-1:0] tq [4] = '{10'd0, 10'd1023, 10'd30, 10'd960};
    logic         to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat, bcnt;
    logic [W-1:0] q;
    logic o;
    for (int k = 0; k < 4; k++) begin
      do_op(ta[k], tb[k], lat, bcnt, q, o);
      checks++;
      if (q !== tq[k] || o !== to[k]) begin
        errors++;
        $display("FAIL limit_%0dx%0d got=%0d/%b exp=%0d/%b", ta[k], tb[k], q, o, tq[k], to[k]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic [W-1:0] a, b, q, eq;
    logic o, eo;
    for (int k = 0; k < 30; k++) begin
      a = W'($urandom_range(0, 1023));
      b = W'($urandom_range(0, 1023));
      do_op(a, b, lat, bcnt, q, o);
      model(a, b, eq, eo);
      checks++;
      if (q !== eq || o !== eo || lat !== 10) begin
        errors++;
        $display("FAIL random_%0dx%0d got=%0d/%b lat=%0d exp=%0d/%b lat=10", a, b, q, o, lat, eq, eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcyc [$];
    int cyc;
    logic [W-1:0] a, b, eq;
    logic eo;
    a = W'($urandom_range(0, 1023));
    b = W'($urandom_range(0, 1023));
    model(a, b, eq, eo);
    @(negedge clk);
    in_a = a; in_b = b; start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (valid) begin
        vcyc.push_back(cyc);
        checks++;
        if (qout !== eq || ovf !== eo) begin errors++; $display("FAIL b2b_result got=%0d/%b exp=%0d/%b", qout, ovf, eq, eo); end
      end
    end
    start = 1'b0;
    checks++; if (vcyc.size() !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", vcyc.size()); end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++;
      if (vcyc[i] - vcyc[i-1] !== 12) begin errors++; $display("FAIL b2b_period got=%0d exp=12", vcyc[i] - vcyc[i-1]); end
    end
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int vcount;
    logic [W-1:0] a, b, eq, q;
    logic eo, o;
    a = W'($urandom_range(0, 1023));
    b = W'($urandom_range(0, 1023));
    model(a, b, eq, eo);
    @(negedge clk);
    in_a = a; in_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcount = 0;
    q = '0; o = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i >= 2 && i <= 5) begin
        start = 1'b1;
        in_a  = ~a;
        in_b  = W'($urandom_range(0, 1023));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (valid) begin vcount++; q = qout; o = ovf; end
    end
    start = 1'b0;
    checks++; if (vcount !== 1) begin errors++; $display("FAIL ignore_start_pulses got=%0d exp=1", vcount); end
    checks++; if (q !== eq || o !== eo) begin errors++; $display("FAIL operand_hold got=%0d/%b exp=%0d/%b", q, o, eq, eo); end
  endtask

  task automatic test_sclr();
    int lat, bcnt, vcount;
    logic [W-1:0] q, eq;
    logic o, eo;
    do_op(10'd1023, 10'd1023, lat, bcnt, q, o);
    @(negedge clk);
    in_a = 10'd300; in_b = 10'd400; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); sclr = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL sclr_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL sclr_valid got=%b exp=0", valid); end
    checks++; if (qout !== '0 || ovf !== 1'b0) begin errors++; $display("FAIL sclr_outputs got=%0d/%b exp=0/0", qout, ovf); end
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid || busy) vcount++;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL sclr_idle got=%0d exp=0", vcount); end
    do_op(10'd64, 10'd80, lat, bcnt, q, o);
    model(10'd64, 10'd80, eq, eo);
    checks++; if (q !== eq || o !== eo) begin errors++; $display("FAIL sclr_restart got=%0d/%b exp=%0d/%b", q, o, eq, eo); end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_limits();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_sclr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_fixed_multiplier.md
Name: seq_fixed_multiplier

Overview:
- Sequential unsigned fixed-point shift-add multiplier. It is the inverse-operation companion of the team's sequential divider: same operand format, same start/busy/valid/ovf handshake.
- Together the two blocks form the multiply/divide pair of the arithmetic unit.
- Single controller FSM plus datapath (multiplicand register, multiplier shift register, accumulator, iteration counter) in one module.

Parameters:
- WIDTH, 10, operand and result width in bits.
- FRAC, 5, number of fractional bits (Q(WIDTH-FRAC).FRAC format); 1.0 = 2^FRAC.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sclr  input  1  synchronous clear; same effect as reset, taken on the clock edge; priority over start.
- in_a  input  WIDTH  multiplicand, sampled on the start edge.
- in_b  input  WIDTH  multiplier, sampled on the start edge.
- start  input  1  begin operation; honoured only in IDLE.
- busy  output  1  high while iterating (CALC state).
- valid  output  1  one-cycle pulse; qout/ovf are fresh.
- ovf  output  1  truncated result exceeds WIDTH bits.
- qout  output  WIDTH  product, fixed-point, truncated.

Behaviour:
- Reset (rst_n=0 or sclr=1): state IDLE; busy=0, valid=0, ovf=0, qout=0; internal registers and counter cleared.
  - rst_n acts immediately.
  - sclr acts at the next edge.
  - Either one aborts an operation mid-flight with no valid pulse.
- States: IDLE, CALC, DONE.
  - IDLE: when start=1 at edge E0:
    - A <- in_a.
    - B <- in_b.
    - ACC (2*WIDTH+1 bits incl. carry) <- 0.
    - cnt <- 0.
    - go to CALC.
    - Otherwise stay in IDLE.
  - CALC: each edge performs one iteration:
    - if B[0], ACC[2W:W] <- ACC[2W-1:W] + A.
    - then shift {ACC,B} right by 1.
    - cnt <- cnt+1.
    - The iteration performed with cnt==WIDTH-1 is the last; that edge moves the state to DONE.
  - Entry into DONE (same edge as the last iteration): with full product P[2W-1:0]:
    - qout <- P[WIDTH+FRAC-1:FRAC].
    - ovf <- OR of P[2W-1:WIDTH+FRAC].
  - DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- busy=1 exactly in CALC: WIDTH cycles, from after E0 through edge E_WIDTH.
- valid=1 exactly in DONE: asserted after edge E_WIDTH, deasserted after E_WIDTH+1.
- Latency: valid rises WIDTH clock edges after the start-sampling edge; the next start is accepted at edge E_WIDTH+2 at the earliest.
- start while in CALC or DONE is ignored; it is not queued.
- in_a/in_b changes after E0 have no effect on the running operation.
- qout and ovf hold their values from the last completed operation until the next DONE entry or a reset. They are not cleared at start.
- Arithmetic:
  - unsigned, truncation toward zero (dropped FRAC LSBs, no rounding).
  - On ovf=1, qout still carries the low WIDTH bits of P>>FRAC (wrap, no saturation).
- cnt width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.

Test Plan:
- Reset: hold rst_n=0 mid-CALC (3 cycles after start) -> busy, valid, ovf and qout all go to 0 immediately; after release, no valid pulse; IDLE accepts a new start.
- Basic: in_a=32 (1.0), in_b=48 (1.5), start 1 cycle -> busy high 10 cycles; valid pulse 10 edges after the sampling edge; qout=48, ovf=0. Also in_a=0, in_b=777 -> qout=0.
- Truncation/limit:
  - a=1, b=1 -> qout=0, ovf=0.
  - a=1023, b=32 -> qout=1023, ovf=0.
  - a=1023, b=33 -> qout=30 (1054 mod 1024), ovf=1.
- Overflow wrap: a=1023, b=1023 -> P=1046529, qout=960, ovf=1.
- Handshake:
  - start held high continuously -> operations back-to-back with a period of 12 cycles.
  - start pulsed during CALC -> ignored; exactly one valid pulse.
  - in_a/in_b changed during CALC -> result unaffected.
- sclr: assert sclr for 1 cycle during CALC with start=1 also high -> outputs 0 after the edge, state IDLE, no valid; the next start produces a correct result.
